store_buffer: RTL and testbench

- Consumer end of the store-path interface.
- Accepts the generated store (WE_AG, StrAddr_AG, store_data_AG) into an in-order circular buffer.
- Holds each entry speculative until the ROB commits it, then drains committed entries to data memory over a req/ack handshake.
- Provides combinational store-to-load forwarding to the load path, and discards uncommitted entries on flush.

---
 rtl/sb_pkg.sv | 26 ++
 rtl/sb_fwd_match.sv | 38 +++
 rtl/store_buffer.sv | 197 +++++++++++++++++++
 tb/tb_store_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer.
package sb_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;

    // Per-entry lifecycle
    typedef enum logic [1:0] {
        ENT_FREE = 2'd0,
        ENT_PEND = 2'd1,
        ENT_CMT  = 2'd2
    } ent_st_e;

    // Memory drain handshake
    typedef enum logic {
        DR_IDLE  = 1'b0,
        DR_WRITE = 1'b1
    } drain_st_e;

    // Pointer width for a ring of the given depth (at least one bit)
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match store-to-load forwarding lookup over the ring.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned WAW   = SB_AW - 2,
    parameter int unsigned DW    = SB_DW,
    parameter int unsigned PW    = ptr_w(SB_DEPTH)
) (
    input  logic                      lookup_en,
    input  logic [WAW-1:0]            ld_waddr,
    input  logic [DEPTH-1:0]          ent_valid,
    input  logic [DEPTH-1:0][WAW-1:0] ent_waddr,
    input  logic [DEPTH-1:0][DW-1:0]  ent_data,
    input  logic [PW-1:0]             tail,
    output logic                      hit_c,
    output logic [DW-1:0]             data_c
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest starting at tail; the last match seen is the youngest
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        idx    = '0;
        if (lookup_en) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                idx = tail + PW'(k);
                if (ent_valid[idx] && (ent_waddr[idx] == ld_waddr)) begin
                    hit_c  = 1'b1;
                    data_c = ent_data[idx];
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: speculative until commit, drained to memory over req/ack,
// with combinational store-to-load forwarding and flush of uncommitted entries.
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    WE_AG,
    input  logic [AW-1:0]           StrAddr_AG,
    input  logic [DW-1:0]           store_data_AG,
    output logic                    sb_full,
    output logic                    sb_ovf,
    input  logic                    commit_i,
    input  logic                    flush_i,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_data,
    input  logic                    mem_ack,
    input  logic                    ld_valid,
    input  logic [AW-1:0]           ld_addr,
    output logic                    fwd_hit,
    output logic [DW-1:0]           fwd_data,
    output logic [ptr_w(DEPTH):0]   sb_count
);

    localparam int unsigned PW  = ptr_w(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned WAW = AW - 2;

    ent_st_e                 st_q [DEPTH];
    ent_st_e                 st_n [DEPTH];
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;

    logic [PW-1:0] head_q, cmt_q, tail_q;
    logic [PW-1:0] head_n, cmt_n, tail_n;
    logic [CW-1:0] count_q, count_n;
    logic [CW-1:0] pend_q, pend_n, pend_after;
    logic          full_q, ovf_q;

    drain_st_e     dr_q, dr_n;
    logic          mem_we_q, mem_we_n;
    logic [AW-1:0] mem_addr_q, mem_addr_n;
    logic [DW-1:0] mem_data_q, mem_data_n;
    logic          done;

    logic          enq, cmt_ok;

    logic [DEPTH-1:0]          ent_valid;
    logic [DEPTH-1:0][WAW-1:0] ent_waddr;
    logic                      ld_addr_unused;

    // Enqueue sees the registered full flag; flush takes priority over a new store
    assign enq        = WE_AG && !full_q && !flush_i;
    assign cmt_ok     = commit_i && (pend_q != {CW{1'b0}});
    assign pend_after = pend_q - CW'(cmt_ok);

    // Entry state, pointer and occupancy next-state (commit is applied before flush)
    always_comb begin
        st_n   = st_q;
        head_n = head_q;
        cmt_n  = cmt_q;
        tail_n = tail_q;
        if (enq) begin
            st_n[tail_q] = ENT_PEND;
            tail_n       = tail_q + PW'(1);
        end
        if (cmt_ok) begin
            st_n[cmt_q] = ENT_CMT;
            cmt_n       = cmt_q + PW'(1);
        end
        if (flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (st_n[i] == ENT_PEND) begin
                    st_n[i] = ENT_FREE;
                end
            end
            tail_n = cmt_n;
        end
        if (done) begin
            st_n[head_q] = ENT_FREE;
            head_n       = head_q + PW'(1);
        end
        count_n = count_q + CW'(enq) - CW'(done) - (flush_i ? pend_after : {CW{1'b0}});
        pend_n  = flush_i ? {CW{1'b0}} : (pend_after + CW'(enq));
    end

    // Drain FSM next-state and registered memory-port values
    always_comb begin
        dr_n       = dr_q;
        mem_we_n   = mem_we_q;
        mem_addr_n = mem_addr_q;
        mem_data_n = mem_data_q;
        done       = 1'b0;
        case (dr_q)
            DR_IDLE: begin
                // Head entry committed already, or being committed on this edge
                if ((st_q[head_q] == ENT_CMT) || (cmt_ok && (cmt_q == head_q))) begin
                    dr_n       = DR_WRITE;
                    mem_we_n   = 1'b1;
                    mem_addr_n = addr_q[head_q];
                    mem_data_n = data_q[head_q];
                end
            end
            DR_WRITE: begin
                if (mem_ack) begin
                    done     = 1'b1;
                    dr_n     = DR_IDLE;
                    mem_we_n = 1'b0;
                end
            end
            default: begin
                dr_n = DR_IDLE;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                st_q[i] <= ENT_FREE;
            end
            head_q     <= '0;
            cmt_q      <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dr_q       <= DR_IDLE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            st_q       <= st_n;
            head_q     <= head_n;
            cmt_q      <= cmt_n;
            tail_q     <= tail_n;
            count_q    <= count_n;
            pend_q     <= pend_n;
            full_q     <= (count_n == CW'(DEPTH));
            ovf_q      <= WE_AG && full_q && !flush_i;
            dr_q       <= dr_n;
            mem_we_q   <= mem_we_n;
            mem_addr_q <= mem_addr_n;
            mem_data_q <= mem_data_n;
        end
    end

    // Store payload; only read while the owning entry is non-FREE
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= StrAddr_AG;
            data_q[tail_q] <= store_data_AG;
        end
    end

    // Per-entry lookup inputs for forwarding
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_valid[i] = (st_q[i] != ENT_FREE);
            ent_waddr[i] = addr_q[i][AW-1:2];
        end
    end

    // Forwarding is word granular; byte offset of the load is ignored
    assign ld_addr_unused = ^ld_addr[1:0];

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .WAW   (WAW),
        .DW    (DW),
        .PW    (PW)
    ) u_fwd (
        .lookup_en (ld_valid),
        .ld_waddr  (ld_addr[AW-1:2]),
        .ent_valid (ent_valid),
        .ent_waddr (ent_waddr),
        .ent_data  (data_q),
        .tail      (tail_q),
        .hit_c     (fwd_hit),
        .data_c    (fwd_data)
    );

    assign sb_full  = full_q;
    assign sb_ovf   = ovf_q;
    assign sb_count = count_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model plus directed scenarios.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          WE_AG = 1'b0;
    logic [AW-1:0] StrAddr_AG = '0;
    logic [DW-1:0] store_data_AG = '0;
    logic          sb_full, sb_ovf;
    logic          commit_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack = 1'b0;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [2:0]    sb_count;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .WE_AG         (WE_AG),
        .StrAddr_AG    (StrAddr_AG),
        .store_data_AG (store_data_AG),
        .sb_full       (sb_full),
        .sb_ovf        (sb_ovf),
        .commit_i      (commit_i),
        .flush_i       (flush_i),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_ack       (mem_ack),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
        .sb_count      (sb_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of stores, oldest first
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        cmt;
    } m_ent_t;

    m_ent_t      mq[$];
    m_ent_t      keep[$];
    m_ent_t      ne;
    logic        m_we = 1'b0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_full, m_writing;

    function automatic void m_fwd(input logic [31:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].addr[31:2] == a[31:2]) begin
                h = 1'b1;
                d = mq[i].data;
            end
        end
    endfunction

    // Advance the model on each clock edge from the inputs seen at that edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_we   = 1'b0;
            m_ovf  = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            m_full    = (mq.size() == DEPTH);
            m_writing = m_we;
            if (m_we && mem_ack) begin
                void'(mq.pop_front());
                m_we = 1'b0;
            end
            if (commit_i) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].cmt) begin
                        mq[i].cmt = 1'b1;
                        break;
                    end
                end
            end
            if (flush_i) begin
                keep.delete();
                foreach (mq[i]) if (mq[i].cmt) keep.push_back(mq[i]);
                mq = keep;
            end
            m_ovf = WE_AG && m_full && !flush_i;
            if (WE_AG && !m_full && !flush_i) begin
                ne.addr = StrAddr_AG;
                ne.data = store_data_AG;
                ne.cmt  = 1'b0;
                mq.push_back(ne);
            end
            if (!m_writing && (mq.size() > 0) && mq[0].cmt) begin
                m_we   = 1'b1;
                m_addr = mq[0].addr;
                m_data = mq[0].data;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    logic        e_hit;
    logic [31:0] e_data;
    always @(negedge clk) begin
        if (rst_n) begin
            m_fwd(ld_addr, e_hit, e_data);
            if (!ld_valid) begin
                e_hit  = 1'b0;
                e_data = '0;
            end
            chk("mdl_mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) begin
                chk("mdl_mem_addr", mem_addr, m_addr);
                chk("mdl_mem_data", mem_data, m_data);
            end
            chk("mdl_sb_full", 32'(sb_full), 32'(mq.size() == DEPTH));
            chk("mdl_sb_ovf", 32'(sb_ovf), 32'(m_ovf));
            chk("mdl_sb_count", 32'(sb_count), 32'(mq.size()));
            chk("mdl_fwd_hit", 32'(fwd_hit), 32'(e_hit));
            chk("mdl_fwd_data", fwd_data, e_data);
        end
    end

    // Observation of the memory port for literal scenario checks
    int          we_cycles = 0;
    int          ovf_pulses = 0;
    logic [63:0] wlog[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) we_cycles++;
            if (sb_ovf) ovf_pulses++;
            if (mem_we && mem_ack) wlog.push_back({mem_addr, mem_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        WE_AG = 1'b1;
        StrAddr_AG = a;
        store_data_AG = d;
        step();
        WE_AG = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_sb_count", 32'(sb_count), 32'd0);
        chk("rst_sb_full", 32'(sb_full), 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Single store then commit; ack after two cycles in WRITE
        we_cycles = 0;
        wlog.delete();
        store(32'h100, 32'hDEADBEEF);
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        chk("t1_we_early", 32'(mem_we), 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_data", mem_data, 32'hDEADBEEF);
        step();
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("t1_we_cycles", 32'(we_cycles), 32'd3);
        chk("t1_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() >= 1) begin
            chk("t1_log_addr", wlog[0][63:32], 32'h100);
            chk("t1_log_data", wlog[0][31:0], 32'hDEADBEEF);
        end
        chk("t1_count", 32'(sb_count), 32'd0);

        // Fill and overflow
        ovf_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            store(32'h400 + 32'(4 * i), 32'(i));
            if (i == 3) begin
                chk("t2_full_after4", 32'(sb_full), 32'd1);
                chk("t2_count4", 32'(sb_count), 32'd4);
            end
        end
        step();
        chk("t2_ovf_pulses", 32'(ovf_pulses), 32'd1);
        chk("t2_count_after", 32'(sb_count), 32'd4);
        chk("t2_ovf_low", 32'(sb_ovf), 32'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("t2_flush_count", 32'(sb_count), 32'd0);
        chk("t2_flush_full", 32'(sb_full), 32'd0);

        // Forwarding priority and visibility
        store(32'h200, 32'h11);
        store(32'h200, 32'h22);
        ld_valid = 1'b1;
        ld_addr = 32'h202;
        #1;
        chk("t3_hit", 32'(fwd_hit), 32'd1);
        chk("t3_youngest", fwd_data, 32'h22);
        ld_addr = 32'h300;
        #1;
        chk("t3_miss", 32'(fwd_hit), 32'd0);
        chk("t3_miss_data", fwd_data, 32'd0);
        ld_valid = 1'b0;
        ld_addr = 32'h200;
        #1;
        chk("t3_noload_hit", 32'(fwd_hit), 32'd0);
        chk("t3_noload_data", fwd_data, 32'd0);
        ld_valid = 1'b1;
        ld_addr = 32'h20C;
        WE_AG = 1'b1;
        StrAddr_AG = 32'h20C;
        store_data_AG = 32'h33;
        #1;
        chk("t3_same_edge_miss", 32'(fwd_hit), 32'd0);
        step();
        WE_AG = 1'b0;
        chk("t3_next_cycle_hit", 32'(fwd_hit), 32'd1);
        chk("t3_next_cycle_data", fwd_data, 32'h33);
        ld_valid = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // Flush after one commit: only the committed store drains
        wlog.delete();
        store(32'h500, 32'h1);
        store(32'h504, 32'h2);
        store(32'h508, 32'h3);
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("t4_count", 32'(sb_count), 32'd1);
        ld_valid = 1'b1;
        ld_addr = 32'h504;
        #1;
        chk("t4_squashed_miss", 32'(fwd_hit), 32'd0);
        ld_addr = 32'h500;
        #1;
        chk("t4_draining_hit", 32'(fwd_hit), 32'd1);
        chk("t4_draining_data", fwd_data, 32'h1);
        ld_valid = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("t4_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() >= 1) chk("t4_log_addr", wlog[0][63:32], 32'h500);
        chk("t4_count_end", 32'(sb_count), 32'd0);

        // Commit and flush on the same edge, then wrap the ring
        wlog.delete();
        store(32'h600, 32'hA);
        store(32'h604, 32'hB);
        commit_i = 1'b1;
        flush_i = 1'b1;
        step();
        commit_i = 1'b0;
        flush_i = 1'b0;
        chk("t5_count", 32'(sb_count), 32'd1);
        chk("t5_we", 32'(mem_we), 32'd1);
        chk("t5_addr", mem_addr, 32'h600);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            store(32'h700 + 32'(4 * i), 32'h1000 + 32'(i));
            commit_i = 1'b1;
            step();
            commit_i = 1'b0;
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        step();
        chk("t5_nwrites", 32'(wlog.size()), 32'd7);
        if (wlog.size() == 7) begin
            chk("t5_log0_addr", wlog[0][63:32], 32'h600);
            chk("t5_log0_data", wlog[0][31:0], 32'hA);
            for (int i = 0; i < 6; i++) begin
                chk("t5_order_addr", wlog[i+1][63:32], 32'h700 + 32'(4 * i));
                chk("t5_order_data", wlog[i+1][31:0], 32'h1000 + 32'(i));
            end
        end
        chk("t5_count_end", 32'(sb_count), 32'd0);

        // Asynchronous reset in the middle of a write
        store(32'h800, 32'h55);
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        step();
        chk("t6_we_before", 32'(mem_we), 32'd1);
        ld_valid = 1'b1;
        ld_addr = 32'h800;
        #1;
        chk("t6_hit_before", 32'(fwd_hit), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", 32'(mem_we), 32'd0);
        chk("t6_rst_addr", mem_addr, 32'd0);
        chk("t6_rst_data", mem_data, 32'd0);
        chk("t6_rst_count", 32'(sb_count), 32'd0);
        chk("t6_rst_full", 32'(sb_full), 32'd0);
        chk("t6_rst_ovf", 32'(sb_ovf), 32'd0);
        chk("t6_rst_hit", 32'(fwd_hit), 32'd0);
        chk("t6_rst_fdata", fwd_data, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        ld_valid = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("t6_post_we", 32'(mem_we), 32'd0);
        chk("t6_post_count", 32'(sb_count), 32'd0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
